// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin / select-driven stream multiplexer.
package stream_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Widest channel count the onehot helper supports; callers slice down to N_CH.
    localparam int MAX_CH = 32;

    function automatic logic [MAX_CH-1:0] onehot(input int unsigned idx);
        return {{(MAX_CH-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 upward, wrapping, and
// returns a one-hot grant for the first requesting channel.
module rr_arbiter #(
    parameter  int N_CH  = 4,
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  gnt
);

    logic             found;
    logic [SEL_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = SEL_W'((int'(ptr) + k) % N_CH);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream multiplexer; a grant is held from the first beat
// of a packet until its last beat, chosen by external select or round-robin.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int W     = 8,
    parameter  int MODE  = MODE_SEL,
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH*W-1:0]   in_data,
    input  logic [N_CH-1:0]     in_valid,
    input  logic [N_CH-1:0]     in_last,
    output logic [N_CH-1:0]     in_ready,
    input  logic [SEL_W-1:0]    sel,
    output logic [W-1:0]        out_data,
    output logic                out_valid,
    output logic                out_last,
    input  logic                out_ready,
    output logic [N_CH-1:0]     grant,
    output state_e              dbg_state,
    output logic [SEL_W-1:0]    dbg_ptr
);

    state_e            state_q, state_d;
    logic [N_CH-1:0]   grant_q, grant_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [W-1:0]      out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;

    logic [MAX_CH-1:0] sel_oh_full;
    logic [N_CH-1:0]   sel_oh, rr_gnt, idle_gnt;
    logic              accept, beat_last;
    logic [W-1:0]      beat_data;
    logic [SEL_W-1:0]  g_idx;

    // An out-of-range select falls outside the slice, giving an all-zero mask.
    always_comb sel_oh_full = onehot(32'(sel));
    assign sel_oh = sel_oh_full[N_CH-1:0];

    generate
        if (MODE == MODE_RR) begin : g_rr
            rr_arbiter #(.N_CH(N_CH)) u_arb (
                .req (in_valid),
                .ptr (ptr_q),
                .gnt (rr_gnt)
            );
        end else begin : g_sel
            assign rr_gnt = '0;
        end
    endgenerate

    always_comb begin
        idle_gnt = (MODE == MODE_RR) ? rr_gnt
                 : ((|(in_valid & sel_oh)) ? sel_oh : '0);
        in_ready = (state_q == LOCKED)
                 ? (grant_q & {N_CH{~out_valid_q | out_ready}}) : '0;
        accept   = |(in_valid & in_ready);

        // AND-OR select over the one-hot grant.
        beat_data = '0;
        g_idx     = '0;
        for (int i = 0; i < N_CH; i++) begin
            beat_data = beat_data | (in_data[i*W +: W] & {W{grant_q[i]}});
            if (grant_q[i]) g_idx = SEL_W'(i);
        end
        beat_last = |(in_last & grant_q);

        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (|idle_gnt) begin
                    state_d = LOCKED;
                    grant_d = idle_gnt;
                end
            end
            LOCKED: begin
                if (accept && beat_last) begin
                    state_d = IDLE;
                    grant_d = '0;
                    if (MODE == MODE_RR) ptr_d = g_idx;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            out_data_d  = beat_data;
            out_last_d  = beat_last;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ptr_q       <= SEL_W'(N_CH - 1);
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign grant     = grant_q;
    assign dbg_state = state_q;
    assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: one select-mode and one round-robin instance, cycle
// vector table plus scoreboarded packet sequences.
module tb_stream_mux_rr;
    import stream_mux_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N*W-1:0] a_in_data,  b_in_data;
    logic [N-1:0]   a_in_valid, b_in_valid, a_in_last, b_in_last;
    logic [N-1:0]   a_in_ready, b_in_ready, a_grant, b_grant;
    logic [1:0]     a_sel, b_sel, a_dbg_ptr, b_dbg_ptr;
    logic [W-1:0]   a_out_data, b_out_data;
    logic           a_out_valid, b_out_valid, a_out_last, b_out_last;
    logic           a_out_ready, b_out_ready;
    state_e         a_dbg_state, b_dbg_state;

    stream_mux_rr #(.N_CH(N), .W(W), .MODE(MODE_SEL)) u_sel (
        .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_last(a_in_last), .in_ready(a_in_ready), .sel(a_sel),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_last(a_out_last),
        .out_ready(a_out_ready), .grant(a_grant),
        .dbg_state(a_dbg_state), .dbg_ptr(a_dbg_ptr)
    );

    stream_mux_rr #(.N_CH(N), .W(W), .MODE(MODE_RR)) u_rr (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_last(b_in_last), .in_ready(b_in_ready), .sel(b_sel),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_last(b_out_last),
        .out_ready(b_out_ready), .grant(b_grant),
        .dbg_state(b_dbg_state), .dbg_ptr(b_dbg_ptr)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [W:0] exp_qa[$];
    logic [W:0] exp_qb[$];
    logic [W:0] ea, eb;
    bit sb_en_a = 1'b0;
    bit sb_en_b = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Scoreboards: every completed output handshake must match the next expected {last,data}.
    always @(negedge clk) begin
        if (sb_en_a && a_out_valid && a_out_ready) begin
            if (exp_qa.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL sb_a: unexpected beat 0x%0h, expected none", {a_out_last, a_out_data});
            end else begin
                ea = exp_qa.pop_front();
                check("sb_a beat", 32'({a_out_last, a_out_data}), 32'(ea));
            end
        end
        if (sb_en_b && b_out_valid && b_out_ready) begin
            if (exp_qb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL sb_b: unexpected beat 0x%0h, expected none", {b_out_last, b_out_data});
            end else begin
                eb = exp_qb.pop_front();
                check("sb_b beat", 32'({b_out_last, b_out_data}), 32'(eb));
            end
        end
    end

    task automatic drive_pkt_a(input int ch, input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) begin
            logic [7:0] d;
            logic       lst;
            bit         acc;
            int         waitc;
            d   = base + 8'(k);
            lst = (k == n - 1);
            a_in_data  = 32'(d) << (8 * ch);
            a_in_valid = 4'b0001 << ch;
            a_in_last  = lst ? (4'b0001 << ch) : 4'b0000;
            exp_qa.push_back({lst, d});
            acc   = 1'b0;
            waitc = 0;
            while (!acc && waitc < 40) begin
                @(negedge clk);
                acc = |(a_in_valid & a_in_ready);
                tick();
                waitc++;
            end
            if (!acc) begin
                tests_run++;
                tests_failed++;
                $display("FAIL drive_a ch%0d beat %0d: accepted=0, required=1 within 40 cycles", ch, k);
            end
        end
        a_in_valid = '0;
        a_in_last  = '0;
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [31:0] data;
        logic [3:0]  exp_grant;
        logic        exp_ovalid;
        logic [7:0]  exp_odata;
        logic        exp_olast;
        logic [3:0]  exp_irdy;
        logic        chk_data;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [31:0] bus_a(input logic [7:0] d2);
        return {8'h13, d2, 8'h11, 8'h10};
    endfunction

    logic [3:0] exp_g;

    initial begin
        // ch2 sends A1..A3 under sel=2; sel moves to 0 mid-packet while ch0 waits
        // with a single-beat packet.
        vecs[0] = '{2'd2, 4'b0000, 4'b0000, bus_a(8'hA1), 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b1};
        vecs[1] = '{2'd2, 4'b0100, 4'b0000, bus_a(8'hA1), 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0};
        vecs[2] = '{2'd2, 4'b0100, 4'b0000, bus_a(8'hA1), 4'b0100, 1'b0, 8'h00, 1'b0, 4'b0100, 1'b0};
        vecs[3] = '{2'd0, 4'b0101, 4'b0000, bus_a(8'hA2), 4'b0100, 1'b1, 8'hA1, 1'b0, 4'b0100, 1'b1};
        vecs[4] = '{2'd0, 4'b0101, 4'b0101, bus_a(8'hA3), 4'b0100, 1'b1, 8'hA2, 1'b0, 4'b0100, 1'b1};
        vecs[5] = '{2'd0, 4'b0001, 4'b0001, bus_a(8'hA3), 4'b0000, 1'b1, 8'hA3, 1'b1, 4'b0000, 1'b1};
        vecs[6] = '{2'd0, 4'b0001, 4'b0001, bus_a(8'hA3), 4'b0001, 1'b0, 8'h00, 1'b0, 4'b0001, 1'b0};
        vecs[7] = '{2'd0, 4'b0000, 4'b0000, bus_a(8'hA3), 4'b0000, 1'b1, 8'h10, 1'b1, 4'b0000, 1'b1};
        vecs[8] = '{2'd0, 4'b0000, 4'b0000, bus_a(8'hA3), 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0};

        a_in_data = '0; a_in_valid = '0; a_in_last = '0; a_sel = '0; a_out_ready = 1'b1;
        b_in_data = '0; b_in_valid = '0; b_in_last = '0; b_sel = '0; b_out_ready = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 9; i++) begin
            tick();
            rst         = 1'b0;
            a_sel       = vecs[i].sel;
            a_in_valid  = vecs[i].vld;
            a_in_last   = vecs[i].lst;
            a_in_data   = vecs[i].data;
            a_out_ready = 1'b1;
            #1;
            check($sformatf("vec%0d grant", i), 32'(a_grant), 32'(vecs[i].exp_grant));
            check($sformatf("vec%0d out_valid", i), 32'(a_out_valid), 32'(vecs[i].exp_ovalid));
            check($sformatf("vec%0d in_ready", i), 32'(a_in_ready), 32'(vecs[i].exp_irdy));
            check($sformatf("vec%0d state", i), 32'(a_dbg_state), (vecs[i].exp_grant != 4'b0) ? 32'd1 : 32'd0);
            if (vecs[i].chk_data) begin
                check($sformatf("vec%0d out_data", i), 32'(a_out_data), 32'(vecs[i].exp_odata));
                check($sformatf("vec%0d out_last", i), 32'(a_out_last), 32'(vecs[i].exp_olast));
            end
            if (i == 0) begin
                check("rr reset grant", 32'(b_grant), 32'h0);
                check("rr reset out_valid", 32'(b_out_valid), 32'h0);
                check("rr reset ptr", 32'(b_dbg_ptr), 32'h3);
                check("rr reset state", 32'(b_dbg_state), 32'h0);
            end
        end

        // Backpressure: first beat 0x5C parks in the output register for 5 cycles.
        sb_en_a     = 1'b1;
        a_out_ready = 1'b0;
        a_sel       = 2'd1;
        fork
            drive_pkt_a(1, 3, 8'h5C);
            begin : bp_stall
                int n;
                n = 0;
                while (!a_out_valid && n < 20) begin
                    tick();
                    n++;
                end
                check("bp out_valid rise", 32'(a_out_valid), 32'h1);
                for (int k = 0; k < 5; k++) begin
                    check("bp hold valid", 32'(a_out_valid), 32'h1);
                    check("bp hold data", 32'(a_out_data), 32'h5C);
                    check("bp in_ready", 32'(a_in_ready), 32'h0);
                    check("bp grant held", 32'(a_grant), 32'h2);
                    tick();
                end
                a_out_ready = 1'b1;
            end
        join
        repeat (3) tick();
        check("bp queue drained", 32'(exp_qa.size()), 32'h0);

        // Round-robin, all channels valid with single-beat packets.
        sb_en_b = 1'b1;
        tick();
        b_in_data  = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
        b_in_valid = 4'hF;
        b_in_last  = 4'hF;
        exp_qb.push_back({1'b1, 8'hB0});
        exp_qb.push_back({1'b1, 8'hB1});
        exp_qb.push_back({1'b1, 8'hB2});
        exp_qb.push_back({1'b1, 8'hB3});
        exp_qb.push_back({1'b1, 8'hB0});
        #1;
        check("rr c0 grant", 32'(b_grant), 32'h0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            #1;
            exp_g = (c % 2 == 1) ? (4'b0001 << (((c - 1) / 2) % 4)) : 4'b0000;
            check($sformatf("rr c%0d grant", c), 32'(b_grant), 32'(exp_g));
            check($sformatf("rr c%0d in_ready", c), 32'(b_in_ready), 32'(exp_g));
            check($sformatf("rr c%0d out_valid", c), 32'(b_out_valid), (c % 2 == 0) ? 32'h1 : 32'h0);
            if (c == 10) b_in_valid = '0;
        end

        // Reset after 2 of 4 beats of a ch2 packet.
        tick();
        b_in_valid = 4'b0100;
        b_in_last  = 4'b0000;
        b_in_data  = 32'hC0 << 16;
        exp_qb.push_back({1'b0, 8'hC0});
        tick();
        #1;
        check("rst pre grant", 32'(b_grant), 32'h4);
        tick();
        b_in_data = 32'hC1 << 16;
        exp_qb.push_back({1'b0, 8'hC1});
        #1;
        check("rst beat1 data", 32'(b_out_data), 32'hC0);
        tick();
        rst       = 1'b1;
        b_in_data = 32'hC2 << 16;
        #1;
        check("rst beat2 data", 32'(b_out_data), 32'hC1);
        tick();
        #1;
        check("rst out_valid", 32'(b_out_valid), 32'h0);
        check("rst grant", 32'(b_grant), 32'h0);
        check("rst state", 32'(b_dbg_state), 32'h0);
        check("rst ptr", 32'(b_dbg_ptr), 32'h3);
        check("rst out_last", 32'(b_out_last), 32'h0);
        rst        = 1'b0;
        b_in_valid = 4'hF;
        b_in_last  = 4'hF;
        b_in_data  = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
        exp_qb.push_back({1'b1, 8'hB0});
        tick();
        #1;
        check("post-rst grant", 32'(b_grant), 32'h1);
        check("post-rst in_ready", 32'(b_in_ready), 32'h1);
        tick();
        b_in_valid = '0;
        #1;
        check("post-rst out_valid", 32'(b_out_valid), 32'h1);
        check("post-rst out_data", 32'(b_out_data), 32'hB0);
        check("post-rst out_last", 32'(b_out_last), 32'h1);
        check("post-rst idle", 32'(b_dbg_state), 32'h0);

        repeat (3) tick();
        check("sb_a empty", 32'(exp_qa.size()), 32'h0);
        check("sb_b empty", 32'(exp_qb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule
